// File: rtl/trace_node_serializer_if.sv
// Commit-side snapshot bus and trace-side word stream of the trace node serializer.
// The serializer is the slave; the commit stage / trace sink pair is the master.
interface trace_node_serializer_if #(
    parameter int XLEN = 32
);
    logic                   commitValid;
    logic                   commitReady;
    logic [3:0]             nodeEnable;
    logic [31:0]            cycle;
    logic [31:0]            opId;
    logic [31:0]            insn;
    logic [XLEN-1:0]        virtualPc;
    logic [XLEN-1:0]        physicalPc;
    logic [32*XLEN-1:0]     regs;
    logic [31:0]            hostIoValue;
    logic                   traceValid;
    logic                   traceReady;
    logic [31:0]            traceData;
    logic                   traceLast;

    modport slave (
        input  commitValid, nodeEnable, cycle, opId, insn, virtualPc, physicalPc,
               regs, hostIoValue, traceReady,
        output commitReady, traceValid, traceData, traceLast
    );

    modport master (
        output commitValid, nodeEnable, cycle, opId, insn, virtualPc, physicalPc,
               regs, hostIoValue, traceReady,
        input  commitReady, traceValid, traceData, traceLast
    );
endinterface

// File: rtl/trace_node_serializer.sv
// Captures one commit snapshot and streams it as a trace record (header plus the
// enabled BasicInfo/Pc/IntReg/Io nodes) of 32-bit words over valid/ready.
module trace_node_serializer #(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rstN,
    trace_node_serializer_if.slave   bus
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("trace_node_serializer: XLEN must be 32 or 64");
        end
    endgenerate

    localparam int PC_WORDS  = 2 * XLEN / 32;
    localparam int REG_WORDS = XLEN;
    localparam int PC_BITS   = $clog2(PC_WORDS);
    localparam int CNT_W     = $clog2(REG_WORDS);

    localparam logic [15:0] BYTES_BI = 16'd32;
    localparam logic [15:0] BYTES_PC = (XLEN == 64) ? 16'd32 : 16'd24;
    localparam logic [15:0] BYTES_IR = (XLEN == 64) ? 16'd272 : 16'd144;
    localparam logic [15:0] BYTES_IO = 16'd24;
    localparam logic [31:0] TYPE_PC  = (XLEN == 64) ? 32'd3 : 32'd2;
    localparam logic [31:0] TYPE_IR  = (XLEN == 64) ? 32'd5 : 32'd4;

    localparam logic [CNT_W:0]   BW_BI   = (CNT_W+1)'(4);
    localparam logic [CNT_W:0]   BW_PC   = (CNT_W+1)'(PC_WORDS);
    localparam logic [CNT_W:0]   BW_IR   = (CNT_W+1)'(REG_WORDS);
    localparam logic [CNT_W:0]   BW_IO   = (CNT_W+1)'(2);
    localparam logic [CNT_W:0]   BW_ONE  = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   BW_TWO  = (CNT_W+1)'(2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_NODE_HDR,
        S_NODE_BODY
    } state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [1:0]         r_node, w_node_next;
    logic               r_valid, w_valid_next;
    logic               r_last, w_last_next;
    logic [31:0]        r_data, w_data_next;

    logic [3:0]         r_mask;
    logic [31:0]        r_cycle, r_op_id, r_insn, r_io;
    logic [2*XLEN-1:0]  r_pc;
    logic [32*XLEN-1:0] r_regs;

    logic               w_hs, w_commit_ready, w_capture;
    logic [2:0]         w_next, w_first;
    logic [CNT_W:0]     w_bw;
    logic [CNT_W-1:0]   w_body_idx;
    logic [31:0]        w_body_word;
    logic [31:0]        w_pc_words  [PC_WORDS];
    logic [31:0]        w_reg_words [REG_WORDS];

    // Wide values are emitted low word first, which is plain 32-bit slicing.
    generate
        for (genvar gi = 0; gi < PC_WORDS; gi++) begin : g_pc_words
            assign w_pc_words[gi] = r_pc[gi*32 +: 32];
        end
        for (genvar gi = 0; gi < REG_WORDS; gi++) begin : g_reg_words
            assign w_reg_words[gi] = r_regs[gi*32 +: 32];
        end
    endgenerate

    function automatic logic [15:0] node_bytes(input logic [1:0] n);
        case (n)
            2'd0:    node_bytes = BYTES_BI;
            2'd1:    node_bytes = BYTES_PC;
            2'd2:    node_bytes = BYTES_IR;
            default: node_bytes = BYTES_IO;
        endcase
    endfunction

    function automatic logic [CNT_W:0] body_words(input logic [1:0] n);
        case (n)
            2'd0:    body_words = BW_BI;
            2'd1:    body_words = BW_PC;
            2'd2:    body_words = BW_IR;
            default: body_words = BW_IO;
        endcase
    endfunction

    function automatic logic [31:0] node_type(input logic [1:0] n);
        case (n)
            2'd0:    node_type = 32'd1;
            2'd1:    node_type = TYPE_PC;
            2'd2:    node_type = TYPE_IR;
            default: node_type = 32'd12;
        endcase
    endfunction

    function automatic logic [15:0] record_bytes(input logic [3:0] mask);
        record_bytes = 16'd8 + (mask[0] ? BYTES_BI : 16'd0) + (mask[1] ? BYTES_PC : 16'd0)
                     + (mask[2] ? BYTES_IR : 16'd0) + (mask[3] ? BYTES_IO : 16'd0);
    endfunction

    // Returns {found, index} of the lowest enabled node at or above lo.
    function automatic logic [2:0] find_node(input logic [3:0] mask, input logic [2:0] lo);
        find_node = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k] && (3'(k) >= lo)) find_node = {1'b1, 2'(k)};
        end
    endfunction

    assign w_hs           = r_valid && bus.traceReady;
    assign w_commit_ready = rstN && ((r_state == S_IDLE) || (w_hs && r_last));
    assign w_capture      = bus.commitValid && w_commit_ready;
    assign w_next         = find_node(r_mask, {1'b0, r_node} + 3'd1);
    assign w_first        = find_node(r_mask, 3'd0);
    assign w_bw           = body_words(r_node);

    assign bus.commitReady = w_commit_ready;
    assign bus.traceValid  = r_valid;
    assign bus.traceData   = r_data;
    assign bus.traceLast   = r_last;

    // Body word for the position about to be presented within the current node.
    always_comb begin
        w_body_idx  = (r_state == S_NODE_BODY) ? r_cnt + CNT_ONE : '0;
        w_body_word = '0;
        case (r_node)
            2'd0: begin
                case (w_body_idx[1:0])
                    2'd0:    w_body_word = r_cycle;
                    2'd1:    w_body_word = r_op_id;
                    2'd2:    w_body_word = r_insn;
                    default: w_body_word = '0;
                endcase
            end
            2'd1:    w_body_word = w_pc_words[w_body_idx[PC_BITS-1:0]];
            2'd2:    w_body_word = w_reg_words[w_body_idx];
            default: w_body_word = w_body_idx[0] ? 32'd0 : r_io;
        endcase
    end

    // Outputs are registered: each transition loads the word for the new position.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_node_next  = r_node;
        w_valid_next = r_valid;
        w_last_next  = r_last;
        w_data_next  = r_data;
        if (w_capture) begin
            w_state_next = S_HEADER;
            w_cnt_next   = '0;
            w_node_next  = '0;
            w_valid_next = 1'b1;
            w_last_next  = 1'b0;
            w_data_next  = 32'(record_bytes(bus.nodeEnable));
        end else if (w_hs) begin
            if (r_last) begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_node_next  = '0;
                w_valid_next = 1'b0;
                w_last_next  = 1'b0;
                w_data_next  = '0;
            end else begin
                case (r_state)
                    S_HEADER: begin
                        if (r_cnt == '0) begin
                            w_cnt_next  = CNT_ONE;
                            w_data_next = '0;
                            w_last_next = (r_mask == 4'd0);
                        end else begin
                            w_state_next = S_NODE_HDR;
                            w_cnt_next   = '0;
                            w_node_next  = w_first[1:0];
                            w_data_next  = 32'(node_bytes(w_first[1:0]));
                        end
                    end
                    S_NODE_HDR: begin
                        if (r_cnt != CNT_HDR) begin
                            w_cnt_next  = r_cnt + CNT_ONE;
                            w_data_next = (r_cnt + CNT_ONE == CNT_TWO) ? node_type(r_node) : 32'd0;
                        end else begin
                            w_state_next = S_NODE_BODY;
                            w_cnt_next   = '0;
                            w_data_next  = w_body_word;
                            w_last_next  = (w_bw == BW_ONE) && !w_next[2];
                        end
                    end
                    S_NODE_BODY: begin
                        if ({1'b0, r_cnt} != w_bw - BW_ONE) begin
                            w_cnt_next  = r_cnt + CNT_ONE;
                            w_data_next = w_body_word;
                            w_last_next = (({1'b0, r_cnt} + BW_TWO) == w_bw) && !w_next[2];
                        end else begin
                            w_state_next = S_NODE_HDR;
                            w_cnt_next   = '0;
                            w_node_next  = w_next[1:0];
                            w_data_next  = 32'(node_bytes(w_next[1:0]));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_node  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_node  <= w_node_next;
            r_valid <= w_valid_next;
            r_last  <= w_last_next;
            r_data  <= w_data_next;
        end
    end

    // Snapshot registers, so the producer may move on right after capture.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mask  <= '0;
            r_cycle <= '0;
            r_op_id <= '0;
            r_insn  <= '0;
            r_io    <= '0;
            r_pc    <= '0;
            r_regs  <= '0;
        end else if (w_capture) begin
            r_mask  <= bus.nodeEnable;
            r_cycle <= bus.cycle;
            r_op_id <= bus.opId;
            r_insn  <= bus.insn;
            r_io    <= bus.hostIoValue;
            r_pc    <= {bus.physicalPc, bus.virtualPc};
            r_regs  <= bus.regs;
        end
    end
endmodule

// File: tb/tb_trace_node_serializer.sv
// Directed bench for trace_node_serializer: XLEN=32 and XLEN=64 instances,
// hand-computed record word lists, stall stability, back-to-back and mid-record reset.
module tb_trace_node_serializer;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    trace_node_serializer_if #(.XLEN(32)) if32();
    trace_node_serializer_if #(.XLEN(64)) if64();

    trace_node_serializer #(.XLEN(32)) u_dut32 (.clk(clk), .rstN(rstN), .bus(if32.slave));
    trace_node_serializer #(.XLEN(64)) u_dut64 (.clk(clk), .rstN(rstN), .bus(if64.slave));

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic commit(input bit use64, input logic [3:0] mask);
        int w = 0;
        @(negedge clk);
        if (use64) begin if64.nodeEnable = mask; if64.commitValid = 1'b1; end
        else       begin if32.nodeEnable = mask; if32.commitValid = 1'b1; end
        while (!(use64 ? if64.commitReady : if32.commitReady) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("commit_accept", 32'(w < 100), 32'd1);
        @(posedge clk);
        #1;
        if (use64) if64.commitValid = 1'b0; else if32.commitValid = 1'b0;
        chk("latency_valid", 32'(use64 ? if64.traceValid : if32.traceValid), 32'd1);
    endtask

    // Takes n_take words of an n_total-word record, checking order, last flag and stall stability.
    task automatic get_record(input string tag, input bit use64, input int n_total,
                              input int n_take, input bit toggle);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic v, l, r;
        logic [31:0] d, held_d;
        logic held_l;
        held_d = '0;
        held_l = 1'b0;
        while (got < n_take && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            r = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (use64) if64.traceReady = r; else if32.traceReady = r;
            v = use64 ? if64.traceValid : if32.traceValid;
            d = use64 ? if64.traceData  : if32.traceData;
            l = use64 ? if64.traceLast  : if32.traceLast;
            if (stalled) begin
                chk({tag, "_stall_valid"}, 32'(v), 32'd1);
                chk($sformatf("%s_stall_data_w%0d", tag, got), d, held_d);
                chk($sformatf("%s_stall_last_w%0d", tag, got), 32'(l), 32'(held_l));
            end
            if (v && r) begin
                chk($sformatf("%s_w%0d", tag, got), d, exp_q[got]);
                chk($sformatf("%s_last_w%0d", tag, got), 32'(l), 32'(got == n_total - 1));
                got++;
                stalled = 1'b0;
            end else if (v) begin
                stalled = 1'b1;
                held_d = d;
                held_l = l;
            end else if (got > 0) begin
                chk({tag, "_valid_midrecord"}, 32'(v), 32'd1);
            end
        end
        chk({tag, "_word_count"}, 32'(got), 32'(n_take));
        if (use64) if64.traceReady = 1'b1; else if32.traceReady = 1'b1;
    endtask

    task automatic set_fields32(input logic [31:0] reg_base);
        if32.cycle       = 32'h11;
        if32.opId        = 32'h22;
        if32.insn        = 32'h33;
        if32.virtualPc   = 32'h1000;
        if32.physicalPc  = 32'h2000;
        if32.hostIoValue = 32'hCAFE_0001;
        for (int i = 0; i < 32; i++) if32.regs[i*32 +: 32] = reg_base + 32'(i);
    endtask

    task automatic build_full32(input logic [31:0] reg_base);
        exp_q = '{32'd232, 32'd0,
                  32'd32, 32'd0, 32'd1, 32'd0, 32'h11, 32'h22, 32'h33, 32'd0,
                  32'd24, 32'd0, 32'd2, 32'd0, 32'h1000, 32'h2000,
                  32'd144, 32'd0, 32'd4, 32'd0};
        for (int i = 0; i < 32; i++) exp_q.push_back(reg_base + 32'(i));
        exp_q.push_back(32'd24);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hCAFE_0001);
        exp_q.push_back(32'd0);
    endtask

    task automatic scramble32();
        if32.cycle = 32'hDEAD_BEEF;
        if32.opId = 32'hDEAD_BEEF;
        if32.insn = 32'hDEAD_BEEF;
        if32.virtualPc = 32'hDEAD_BEEF;
        if32.physicalPc = 32'hDEAD_BEEF;
        if32.hostIoValue = 32'hDEAD_BEEF;
        if32.regs = ~if32.regs;
        if32.nodeEnable = 4'h5;
    endtask

    initial begin
        if32.commitValid = 1'b0; if32.nodeEnable = '0; if32.cycle = '0; if32.opId = '0;
        if32.insn = '0; if32.virtualPc = '0; if32.physicalPc = '0; if32.regs = '0;
        if32.hostIoValue = '0; if32.traceReady = 1'b1;
        if64.commitValid = 1'b0; if64.nodeEnable = '0; if64.cycle = '0; if64.opId = '0;
        if64.insn = '0; if64.virtualPc = '0; if64.physicalPc = '0; if64.regs = '0;
        if64.hostIoValue = '0; if64.traceReady = 1'b1;

        // Reset state
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid32", 32'(if32.traceValid), 32'd0);
        chk("rst_data32", if32.traceData, 32'd0);
        chk("rst_last32", 32'(if32.traceLast), 32'd0);
        chk("rst_ready32", 32'(if32.commitReady), 32'd0);
        chk("rst_valid64", 32'(if64.traceValid), 32'd0);
        chk("rst_ready64", 32'(if64.commitReady), 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        chk("idle_ready32", 32'(if32.commitReady), 32'd1);
        chk("idle_valid32", 32'(if32.traceValid), 32'd0);

        // BasicInfo only, XLEN=32
        if32.cycle = 32'd5; if32.opId = 32'd7; if32.insn = 32'h13;
        commit(1'b0, 4'b0001);
        scramble32();
        exp_q = '{32'd40, 32'd0, 32'd32, 32'd0, 32'd1, 32'd0, 32'd5, 32'd7, 32'h13, 32'd0};
        get_record("t1", 1'b0, 10, 10, 1'b0);
        @(negedge clk);
        chk("t1_idle_after", 32'(if32.traceValid), 32'd0);

        // Pc only, XLEN=64
        if64.virtualPc = 64'h1_0000_2000; if64.physicalPc = 64'h80;
        commit(1'b1, 4'b0010);
        if64.virtualPc = '1; if64.physicalPc = '1;
        exp_q = '{32'd40, 32'd0, 32'd32, 32'd0, 32'd3, 32'd0, 32'h2000, 32'h1, 32'h80, 32'd0};
        get_record("t2", 1'b1, 10, 10, 1'b0);
        @(negedge clk);
        chk("t2_idle_after", 32'(if64.traceValid), 32'd0);

        // All nodes, XLEN=32, traceReady toggling
        set_fields32(32'd0);
        commit(1'b0, 4'hF);
        scramble32();
        build_full32(32'd0);
        get_record("t3", 1'b0, 58, 58, 1'b1);
        @(negedge clk);
        chk("t3_idle_after", 32'(if32.traceValid), 32'd0);

        // Back-to-back empty records with commitValid held
        @(negedge clk);
        if32.nodeEnable = 4'h0; if32.commitValid = 1'b1; if32.traceReady = 1'b1;
        chk("t4_ready_idle", 32'(if32.commitReady), 32'd1);
        @(negedge clk);
        chk("t4_r1w0_data", if32.traceData, 32'd8);
        chk("t4_r1w0_last", 32'(if32.traceLast), 32'd0);
        chk("t4_r1w0_ready", 32'(if32.commitReady), 32'd0);
        @(negedge clk);
        chk("t4_r1w1_data", if32.traceData, 32'd0);
        chk("t4_r1w1_last", 32'(if32.traceLast), 32'd1);
        chk("t4_r1w1_ready", 32'(if32.commitReady), 32'd1);
        @(negedge clk);
        chk("t4_r2w0_valid", 32'(if32.traceValid), 32'd1);
        chk("t4_r2w0_data", if32.traceData, 32'd8);
        chk("t4_r2w0_last", 32'(if32.traceLast), 32'd0);
        if32.commitValid = 1'b0;
        @(negedge clk);
        chk("t4_r2w1_data", if32.traceData, 32'd0);
        chk("t4_r2w1_last", 32'(if32.traceLast), 32'd1);
        @(negedge clk);
        chk("t4_idle_after", 32'(if32.traceValid), 32'd0);

        // Reset at word 20, then a fresh complete record
        set_fields32(32'h100);
        commit(1'b0, 4'hF);
        build_full32(32'h100);
        get_record("t5a", 1'b0, 58, 20, 1'b0);
        @(negedge clk);
        chk("t5_w20_before_rst", if32.traceData, exp_q[20]);
        rstN = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(if32.traceValid), 32'd0);
        chk("t5_rst_data", if32.traceData, 32'd0);
        chk("t5_rst_last", 32'(if32.traceLast), 32'd0);
        chk("t5_rst_ready", 32'(if32.commitReady), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_resume", 32'(if32.traceValid), 32'd0);
        commit(1'b0, 4'hF);
        get_record("t5b", 1'b0, 58, 58, 1'b0);
        @(negedge clk);
        chk("t5_idle_after", 32'(if32.traceValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
